// File: rtl/blackjack_pkg.sv
// Shared types and scoring helpers for the blackjack game engine.
package blackjack_pkg;

    localparam int CARD_W = 4;
    localparam int SUM_W  = 6;

    localparam logic [SUM_W-1:0] BLACKJACK = 6'd21;
    localparam logic [SUM_W-1:0] ACE_BONUS = 6'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_PLAYER,
        S_D_WAIT,
        S_D_DRAW,
        S_RESULT
    } state_t;

    function automatic logic [CARD_W-1:0] card_value(
        input logic [CARD_W-1:0] rank
    );
        if (rank > 4'd10)
            return 4'd10;
        return rank;
    endfunction

    // Soft ace counts as 11 only while that keeps the hand at or below 21.
    function automatic logic [SUM_W-1:0] hand_total(
        input logic [SUM_W-1:0] hard,
        input logic             ace
    );
        if (ace && ((hard + ACE_BONUS) <= BLACKJACK))
            return hard + ACE_BONUS;
        return hard;
    endfunction

    function automatic logic [4:0] sat5(
        input logic [SUM_W-1:0] t
    );
        if (t > 6'd31)
            return 5'd31;
        return t[4:0];
    endfunction

endpackage

// File: rtl/blackjack_card_gen.sv
// Free-running 16-bit Fibonacci LFSR card source with rank filtering.
module blackjack_card_gen
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              iCLK,
    input  logic              iRST,
    output logic              oVALID,
    output logic [CARD_W-1:0] oVALUE,
    output logic              oACE
);

    logic [15:0]       lfsr;
    logic              fb;
    logic [CARD_W-1:0] rank;

    assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign rank = lfsr[3:0];

    always_ff @(posedge iCLK) begin
        if (iRST)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], fb};
    end

    assign oVALID = (rank != 4'd0) && (rank <= 4'd13);
    assign oVALUE = card_value(rank);
    assign oACE   = (rank == 4'd1);

endmodule

// File: rtl/blackjack_game_ctrl.sv
// Blackjack round controller: deal, player turn, paced dealer turn, result.
module blackjack_game_ctrl
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          DEALER_STAND = 17,
    parameter int          DEALER_DELAY = 25000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iNEW_GAME,
    input  logic       iHIT,
    input  logic       iSTAND,
    output logic [4:0] oHAND,
    output logic [4:0] oDEALER,
    output logic       oVICTORY,
    output logic       oDEFEAT,
    output logic       oBUSY
);

    localparam int DW =
        (DEALER_DELAY > 0) ? $clog2(DEALER_DELAY + 1) : 1;
    localparam logic [DW-1:0]    DLY_MAX = DW'(DEALER_DELAY);
    localparam logic [SUM_W-1:0] STAND_T = SUM_W'(DEALER_STAND);

    logic              card_valid;
    logic [CARD_W-1:0] card_value;
    logic              card_ace;

    state_t            state, state_n;
    logic [1:0]        deal_cnt, deal_n;
    logic              hit_pend, pend_n;
    logic [DW-1:0]     dly_cnt, dly_n;
    logic              vic_n, def_n;
    logic              clr, p_add, d_add;

    logic [SUM_W-1:0]  p_hard, d_hard;
    logic              p_ace, d_ace;
    logic [SUM_W-1:0]  p_total, d_total;

    blackjack_card_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_card (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .oVALID (card_valid),
        .oVALUE (card_value),
        .oACE   (card_ace)
    );

    assign p_total = hand_total(p_hard, p_ace);
    assign d_total = hand_total(d_hard, d_ace);

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        deal_n  = deal_cnt;
        pend_n  = hit_pend;
        dly_n   = dly_cnt;
        vic_n   = oVICTORY;
        def_n   = oDEFEAT;
        clr     = 1'b0;
        p_add   = 1'b0;
        d_add   = 1'b0;
        if (iNEW_GAME) begin
            state_n = S_DEAL;
            clr     = 1'b1;
            deal_n  = 2'd0;
            pend_n  = 1'b0;
            dly_n   = '0;
            vic_n   = 1'b0;
            def_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: ;
                S_DEAL: begin
                    if (card_valid) begin
                        // Deal order: player, dealer, player.
                        if (deal_cnt == 2'd1)
                            d_add = 1'b1;
                        else
                            p_add = 1'b1;
                        deal_n = deal_cnt + 2'd1;
                        if (deal_cnt == 2'd2) begin
                            deal_n  = 2'd0;
                            state_n = S_PLAYER;
                        end
                    end
                end
                S_PLAYER: begin
                    if (p_total > BLACKJACK) begin
                        def_n   = 1'b1;
                        pend_n  = 1'b0;
                        state_n = S_RESULT;
                    end else if (p_total == BLACKJACK || iSTAND) begin
                        pend_n  = 1'b0;
                        state_n = S_D_WAIT;
                    end else if ((hit_pend || iHIT) && card_valid) begin
                        p_add  = 1'b1;
                        pend_n = 1'b0;
                    end else if (iHIT) begin
                        pend_n = 1'b1;
                    end
                end
                S_D_WAIT: begin
                    if (d_total >= STAND_T) begin
                        dly_n   = '0;
                        state_n = S_RESULT;
                        if (d_total > BLACKJACK || p_total > d_total)
                            vic_n = 1'b1;
                        else if (p_total < d_total)
                            def_n = 1'b1;
                    end else if (dly_cnt == DLY_MAX) begin
                        dly_n   = '0;
                        state_n = S_D_DRAW;
                    end else begin
                        dly_n = dly_cnt + 1'b1;
                    end
                end
                S_D_DRAW: begin
                    if (card_valid) begin
                        d_add   = 1'b1;
                        state_n = S_D_WAIT;
                    end
                end
                S_RESULT: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            deal_cnt <= 2'd0;
            hit_pend <= 1'b0;
            dly_cnt  <= '0;
            oVICTORY <= 1'b0;
            oDEFEAT  <= 1'b0;
            p_hard   <= '0;
            p_ace    <= 1'b0;
            d_hard   <= '0;
            d_ace    <= 1'b0;
        end else begin
            deal_cnt <= deal_n;
            hit_pend <= pend_n;
            dly_cnt  <= dly_n;
            oVICTORY <= vic_n;
            oDEFEAT  <= def_n;
            if (clr) begin
                p_hard <= '0;
                p_ace  <= 1'b0;
                d_hard <= '0;
                d_ace  <= 1'b0;
            end else begin
                if (p_add) begin
                    p_hard <= p_hard + {2'b00, card_value};
                    p_ace  <= p_ace | card_ace;
                end
                if (d_add) begin
                    d_hard <= d_hard + {2'b00, card_value};
                    d_ace  <= d_ace | card_ace;
                end
            end
        end
    end

    assign oHAND   = sat5(p_total);
    assign oDEALER = sat5(d_total);
    assign oBUSY   = (state == S_DEAL) ||
                     (state == S_D_WAIT) ||
                     (state == S_D_DRAW);

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench: forced card stream, table of rounds plus corner sequences.
module tb_blackjack_game_ctrl;
    import blackjack_pkg::*;

    localparam int ACT_STAND = 0;
    localparam int ACT_HIT   = 1;
    localparam int ACT_NONE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_game, hit, stand;
    logic [4:0] hand, dealer;
    logic       victory, defeat, busy;

    logic       f_valid;
    logic [3:0] f_value;
    logic       f_ace;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] c0, c1, c2;
        int         act;
        logic [3:0] hc;
        logic [3:0] d0, d1, d2;
        logic [4:0] e_hand, e_dealer;
        logic       e_vic, e_def;
    } row_t;

    row_t rows[6];

    blackjack_game_ctrl #(
        .LFSR_SEED    (16'hACE1),
        .DEALER_STAND (17),
        .DEALER_DELAY (4)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iNEW_GAME (new_game),
        .iHIT      (hit),
        .iSTAND    (stand),
        .oHAND     (hand),
        .oDEALER   (dealer),
        .oVICTORY  (victory),
        .oDEFEAT   (defeat),
        .oBUSY     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic give(input logic [3:0] v);
        f_valid = 1'b1;
        f_value = v;
        f_ace   = (v == 4'd1);
        @(negedge clk);
        f_valid = 1'b0;
    endtask

    task automatic deal(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [3:0] c);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        give(a);
        give(b);
        give(c);
    endtask

    task automatic run_row(input row_t r, input int idx);
        int k;
        bit done;
        logic [3:0] dc;
        deal(r.c0, r.c1, r.c2);
        if (r.act == ACT_STAND) begin
            stand = 1'b1;
            @(negedge clk);
            stand = 1'b0;
        end else if (r.act == ACT_HIT) begin
            hit = 1'b1;
            give(r.hc);
            hit = 1'b0;
        end
        k = 0;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            if (dut.state == S_RESULT) begin
                done = 1'b1;
            end else if (dut.state == S_D_DRAW && k < 3) begin
                dc = (k == 0) ? r.d0 : (k == 1) ? r.d1 : r.d2;
                k++;
                give(dc);
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL row%0d_timeout: no result state", idx);
        end
        chk($sformatf("row%0d_hand", idx), 16'(hand), 16'(r.e_hand));
        chk($sformatf("row%0d_dealer", idx),
            16'(dealer), 16'(r.e_dealer));
        chk($sformatf("row%0d_vic", idx), 16'(victory), 16'(r.e_vic));
        chk($sformatf("row%0d_def", idx), 16'(defeat), 16'(r.e_def));
    endtask

    initial begin
        logic [15:0] m;
        force dut.card_valid = f_valid;
        force dut.card_value = f_value;
        force dut.card_ace   = f_ace;
        f_valid  = 1'b0;
        f_value  = 4'd0;
        f_ace    = 1'b0;
        new_game = 1'b0;
        hit      = 1'b0;
        stand    = 1'b0;
        rst      = 1'b1;

        rows[0] = '{4'd1, 4'd6, 4'd1, ACT_STAND, 4'd0,
                    4'd10, 4'd7, 4'd0, 5'd12, 5'd23, 1'b1, 1'b0};
        rows[1] = '{4'd10, 4'd9, 4'd5, ACT_HIT, 4'd8,
                    4'd0, 4'd0, 4'd0, 5'd23, 5'd9, 1'b0, 1'b1};
        rows[2] = '{4'd10, 4'd7, 4'd9, ACT_STAND, 4'd0,
                    4'd10, 4'd0, 4'd0, 5'd19, 5'd17, 1'b1, 1'b0};
        rows[3] = '{4'd10, 4'd7, 4'd7, ACT_STAND, 4'd0,
                    4'd10, 4'd0, 4'd0, 5'd17, 5'd17, 1'b0, 1'b0};
        rows[4] = '{4'd1, 4'd5, 4'd10, ACT_NONE, 4'd0,
                    4'd10, 4'd2, 4'd0, 5'd21, 5'd17, 1'b1, 1'b0};
        rows[5] = '{4'd9, 4'd1, 4'd8, ACT_STAND, 4'd0,
                    4'd7, 4'd0, 4'd0, 5'd17, 5'd18, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_hand", 16'(hand), 16'd0);
        chk("rst_dealer", 16'(dealer), 16'd0);
        chk("rst_vic", 16'(victory), 16'd0);
        chk("rst_def", 16'(defeat), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_state", 16'(dut.state), 16'(S_IDLE));
        chk("rst_lfsr", dut.u_card.lfsr, 16'hACE1);

        m = 16'hACE1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
            @(negedge clk);
            chk($sformatf("lfsr_step%0d", i), dut.u_card.lfsr, m);
        end

        for (int i = 0; i < 6; i++)
            run_row(rows[i], i);

        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("newgame_clr_def", 16'(defeat), 16'd0);
        chk("newgame_state", 16'(dut.state), 16'(S_DEAL));

        deal(4'd10, 4'd9, 4'd5);
        hit = 1'b1;
        give(4'd8);
        hit = 1'b0;
        chk("bust_hand", 16'(hand), 16'd23);
        chk("bust_def_early", 16'(defeat), 16'd0);
        @(negedge clk);
        chk("bust_def", 16'(defeat), 16'd1);
        chk("bust_vic", 16'(victory), 16'd0);
        repeat (10) @(negedge clk);
        chk("bust_dealer_idle", 16'(dealer), 16'd9);

        deal(4'd1, 4'd5, 4'd10);
        chk("bj_hand", 16'(hand), 16'd21);
        @(negedge clk);
        chk("bj_busy", 16'(busy), 16'd1);
        chk("bj_autostand", 16'(dut.state), 16'(S_D_WAIT));

        new_game = 1'b1;
        hit      = 1'b1;
        f_valid  = 1'b1;
        f_value  = 4'd9;
        f_ace    = 1'b0;
        @(negedge clk);
        new_game = 1'b0;
        hit      = 1'b0;
        f_valid  = 1'b0;
        chk("ng_state", 16'(dut.state), 16'(S_DEAL));
        chk("ng_hand", 16'(hand), 16'd0);
        chk("ng_dealer", 16'(dealer), 16'd0);
        chk("ng_busy", 16'(busy), 16'd1);

        deal(4'd10, 4'd2, 4'd3);
        hit   = 1'b1;
        stand = 1'b1;
        give(4'd5);
        hit   = 1'b0;
        stand = 1'b0;
        chk("hs_state", 16'(dut.state), 16'(S_D_WAIT));
        chk("hs_hand", 16'(hand), 16'd13);
        hit = 1'b1;
        give(4'd4);
        hit = 1'b0;
        chk("hit_outside", 16'(hand), 16'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
